// File: rtl/dot_product_seq.sv
// Sequential fixed-point dot-product engine: streams LEN (a,b) pairs through one
// multiplier and a two-stage multiply/accumulate pipeline, then emits one result.
module dot_product_seq #(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 16,
    parameter int LEN    = 5,
    parameter int SAT_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] result,
    output logic              overflow,
    output logic              valid,
    output logic              busy,
    output logic [2:0]        dbg_state
);

    localparam int PROD_W   = 2 * DATA_W;
    localparam int T_W      = PROD_W - FRAC_W;
    localparam int CLOG_LEN = $clog2(LEN);
    localparam int ACC_W    = PROD_W - FRAC_W + CLOG_LEN + 1;
    localparam int CNT_W    = (LEN > 1) ? $clog2(LEN) : 1;

    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'({1'b0, {(DATA_W-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_DRAIN1 = 3'd2,
        S_DRAIN2 = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                   state_q;
    logic [CNT_W-1:0]         cnt_q;
    logic signed [T_W-1:0]    t_q;
    logic                     p_vld_q;
    logic signed [ACC_W-1:0]  acc_q;

    logic signed [PROD_W-1:0] prod_w;
    logic signed [T_W-1:0]    t_d;
    logic signed [ACC_W-1:0]  acc_d;
    logic [DATA_W-1:0]        result_d;
    logic                     overflow_d;
    logic                     accept;

    // Handshake: a pair transfers on a rising edge where in_valid && in_ready;
    // in_ready is high only in RUN and drops on the edge that takes the last pair.
    assign accept    = (state_q == S_RUN) && in_ready && in_valid;
    assign dbg_state = state_q;

    always_comb begin
        prod_w     = PROD_W'($signed(a_in)) * PROD_W'($signed(b_in));
        t_d        = T_W'(prod_w >>> FRAC_W);
        acc_d      = acc_q + ACC_W'(t_q);
        overflow_d = (acc_q > MAX_V) || (acc_q < MIN_V);
        result_d   = acc_q[DATA_W-1:0];
        if (SAT_EN != 0) begin
            if (acc_q > MAX_V) begin
                result_d = MAX_V[DATA_W-1:0];
            end else if (acc_q < MIN_V) begin
                result_d = MIN_V[DATA_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            t_q      <= '0;
            p_vld_q  <= 1'b0;
            acc_q    <= '0;
            result   <= '0;
            overflow <= 1'b0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            in_ready <= 1'b0;
        end else begin
            valid   <= 1'b0;
            p_vld_q <= accept;
            if (accept) begin
                t_q <= t_d;
            end
            if (p_vld_q) begin
                acc_q <= acc_d;
            end

            // Start clears after the pipeline update so a new run always begins from zero.
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q  <= S_RUN;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        p_vld_q  <= 1'b0;
                        busy     <= 1'b1;
                        in_ready <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(LEN - 1)) begin
                            state_q  <= S_DRAIN1;
                            in_ready <= 1'b0;
                        end
                    end
                end
                S_DRAIN1: begin
                    state_q <= S_DRAIN2;
                end
                S_DRAIN2: begin
                    state_q  <= S_DONE;
                    busy     <= 1'b0;
                    valid    <= 1'b1;
                    result   <= result_d;
                    overflow <= overflow_d;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product_seq.sv
// Scoreboard bench for dot_product_seq: a saturating and a wrapping instance share
// stimulus; a negedge monitor pops expected {overflow,result} on every valid pulse.
module tb_dot_product_seq;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] a_in = '0;
  logic [DW-1:0] b_in = '0;
  logic          in_valid = 1'b0;

  logic          in_ready, overflow, valid, busy;
  logic [DW-1:0] result;
  logic [2:0]    dbg_state;
  logic          w_in_ready, w_overflow, w_valid, w_busy;
  logic [DW-1:0] w_result;
  logic [2:0]    w_dbg_state;

  logic [DW:0]   exp_q[$];
  logic [DW:0]   exp_w_q[$];
  logic [DW-1:0] av [0:4];
  logic [DW-1:0] bv [0:4];

  int n_checks = 0;
  int n_fail = 0;

  dot_product_seq #(.DATA_W(32), .FRAC_W(16), .LEN(5), .SAT_EN(1)) dut (
    .clk(clk), .reset(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
    .in_valid(in_valid), .in_ready(in_ready), .result(result),
    .overflow(overflow), .valid(valid), .busy(busy), .dbg_state(dbg_state)
  );

  dot_product_seq #(.DATA_W(32), .FRAC_W(16), .LEN(5), .SAT_EN(0)) dut_w (
    .clk(clk), .reset(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
    .in_valid(in_valid), .in_ready(w_in_ready), .result(w_result),
    .overflow(w_overflow), .valid(w_valid), .busy(w_busy), .dbg_state(w_dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [DW:0] e;
    if (valid === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_valid_sat", 64'd1, 64'd0);
      else begin
        e = exp_q.pop_front();
        check("result_sat", {31'd0, overflow, result}, {31'd0, e});
      end
    end
    if (w_valid === 1'b1) begin
      if (exp_w_q.size() == 0) check("unexpected_valid_wrap", 64'd1, 64'd0);
      else begin
        e = exp_w_q.pop_front();
        check("result_wrap", {31'd0, w_overflow, w_result}, {31'd0, e});
      end
    end
  end

  // driver tasks
  task automatic set_vec(input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                         input logic [DW-1:0] ar, input logic [DW-1:0] br);
    av[0] = a0; bv[0] = b0;
    for (int i = 1; i < 5; i++) begin
      av[i] = ar; bv[i] = br;
    end
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge where valid is seen (the DONE cycle).
  task automatic do_run(input int gap_mode, input int pulse_cyc,
                        input logic [DW:0] es, input logic [DW:0] ew, input int exp_lat);
    int k, acc_cnt, busy_err, idx;
    logic seen;
    exp_q.push_back(es);
    exp_w_q.push_back(ew);
    k = 0; acc_cnt = 0; busy_err = 0; seen = 1'b0;
    check("in_ready_before_run", {63'd0, in_ready}, 64'd0);
    while (!seen && k < 300) begin
      start = (k == 0) || (k == pulse_cyc);
      if (gap_mode == 0) in_valid = 1'b1;
      else in_valid = (k >= 1) && (((k - 1) % 3) == 0);
      idx = (acc_cnt < 5) ? acc_cnt : 4;
      a_in = av[idx];
      b_in = bv[idx];
      if (in_ready && in_valid) acc_cnt++;
      if (k >= 1 && !busy) busy_err++;
      @(negedge clk);
      k++;
      if (valid) seen = 1'b1;
    end
    start = 1'b0;
    in_valid = 1'b0;
    check("valid_latency", 64'(k), 64'(exp_lat));
    check("accept_count", 64'(acc_cnt), 64'd5);
    check("busy_during_run", 64'(busy_err), 64'd0);
    check("busy_low_in_done", {62'd0, busy, in_ready}, 64'd0);
  endtask

  initial begin
    int vcount;
    #12;
    check("reset_outputs", {29'd0, result, overflow, valid, busy, in_ready},
          64'd0);
    check("reset_state", {61'd0, dbg_state}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // basic 1..5 dot 7..11 = 145.0
    av[0] = 32'h0001_0000; av[1] = 32'h0002_0000; av[2] = 32'h0003_0000;
    av[3] = 32'h0004_0000; av[4] = 32'h0005_0000;
    bv[0] = 32'h0007_0000; bv[1] = 32'h0008_0000; bv[2] = 32'h0009_0000;
    bv[3] = 32'h000A_0000; bv[4] = 32'h000B_0000;
    do_run(0, -1, {1'b0, 32'h0091_0000}, {1'b0, 32'h0091_0000}, 8);
    idle(3);
    check("result_holds", {31'd0, overflow, result}, {31'd0, 1'b0, 32'h0091_0000});

    // -1.5 * 2.0 = -3.0
    set_vec(32'hFFFE_8000, 32'h0002_0000, 32'h0, 32'h0);
    do_run(0, -1, {1'b0, 32'hFFFD_0000}, {1'b0, 32'hFFFD_0000}, 8);
    idle(2);

    // tiny negative product floors to -1 LSB
    set_vec(32'hFFFF_FFFF, 32'h0000_8000, 32'h0, 32'h0);
    do_run(0, -1, {1'b0, 32'hFFFF_FFFF}, {1'b0, 32'hFFFF_FFFF}, 8);
    idle(2);

    // positive overflow: 5 * 32767^2 = 5368381445 -> wrap low word 0x00050000
    set_vec(32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000);
    do_run(0, -1, {1'b1, 32'h7FFF_FFFF}, {1'b1, 32'h0005_0000}, 8);
    idle(2);

    // negative overflow: 5 * -32768*32767 = -5368545280 -> wrap low word 0x80000000
    set_vec(32'h8000_0000, 32'h7FFF_0000, 32'h8000_0000, 32'h7FFF_0000);
    do_run(0, -1, {1'b1, 32'h8000_0000}, {1'b1, 32'h8000_0000}, 8);
    idle(2);

    // flow control gaps 1,0,0,... plus a start pulse while busy
    av[0] = 32'h0001_0000; av[1] = 32'h0002_0000; av[2] = 32'h0003_0000;
    av[3] = 32'h0004_0000; av[4] = 32'h0005_0000;
    bv[0] = 32'h0007_0000; bv[1] = 32'h0008_0000; bv[2] = 32'h0009_0000;
    bv[3] = 32'h000A_0000; bv[4] = 32'h000B_0000;
    do_run(1, 3, {1'b0, 32'h0091_0000}, {1'b0, 32'h0091_0000}, 16);
    vcount = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (valid) vcount++;
    end
    check("single_valid_pulse", 64'(vcount), 64'd0);
    check("in_ready_idle", {62'd0, in_ready, w_in_ready}, 64'd0);

    // back-to-back: basic run, then start in the DONE cycle with -1.5*2.0
    do_run(0, -1, {1'b0, 32'h0091_0000}, {1'b0, 32'h0091_0000}, 8);
    set_vec(32'hFFFE_8000, 32'h0002_0000, 32'h0, 32'h0);
    do_run(0, -1, {1'b0, 32'hFFFD_0000}, {1'b0, 32'hFFFD_0000}, 8);
    idle(2);

    // reset mid-RUN after 3 accepted pairs
    av[0] = 32'h0001_0000; av[1] = 32'h0002_0000; av[2] = 32'h0003_0000;
    av[3] = 32'h0004_0000; av[4] = 32'h0005_0000;
    bv[0] = 32'h0007_0000; bv[1] = 32'h0008_0000; bv[2] = 32'h0009_0000;
    bv[3] = 32'h000A_0000; bv[4] = 32'h000B_0000;
    start = 1'b1; in_valid = 1'b1; a_in = av[0]; b_in = bv[0];
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_in = av[i]; b_in = bv[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {29'd0, result, overflow, valid, busy, in_ready}, 64'd0);
    check("async_reset_wrap", {29'd0, w_result, w_overflow, w_valid, w_busy, w_in_ready}, 64'd0);
    vcount = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (valid || w_valid) vcount++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (valid || w_valid) vcount++;
    end
    check("no_valid_after_reset", 64'(vcount), 64'd0);

    do_run(0, -1, {1'b0, 32'h0091_0000}, {1'b0, 32'h0091_0000}, 8);
    idle(4);

    check("scoreboard_drained", 64'(exp_q.size() + exp_w_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
